// File: rtl/counter_event_monitor.sv
// Observer for counter_4bit: sticky event status, saturating wrap count, maskable irq.
// Optional stall detection (stall counter, STALL state, status[2]) enabled by EVT_MON_STALL_DET_EN.
module counter_event_monitor #(
   parameter int CNT_W       = 4,
   parameter int WRAP_W      = 8,
   parameter int STALL_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [CNT_W-1:0]  count,
   input  logic [CNT_W-1:0]  cmp_value,
   input  logic              clr,
   input  logic [3:0]        clr_mask,
   input  logic [3:0]        irq_en,
   output logic [3:0]        status,
   output logic [WRAP_W-1:0] wrap_cnt,
   output logic [1:0]        state,
   output logic              irq
);

   // state | meaning
   // IDLE  | counter disabled
   // RUN   | counter enabled and advancing
   // STALL | enabled but count held for STALL_LIMIT cycles
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  prev_count;
   logic              prev_en;
   logic [CNT_W-1:0]  expected;
   logic              evt_wrap, evt_match, evt_err, evt_stall;
   logic [3:0]        events, clr_bits, status_d;

   assign expected  = prev_en ? prev_count + CNT_W'(1) : prev_count;
   assign evt_wrap  = prev_en && (prev_count == '1) && (count == '0);
   assign evt_match = (count == cmp_value) && (count != prev_count);
   assign evt_err   = (count != expected);

`ifdef EVT_MON_STALL_DET_EN
   localparam int               SC_W  = $clog2(STALL_LIMIT + 1);
   localparam logic [SC_W-1:0]  LIMIT = SC_W'(STALL_LIMIT);

   logic [SC_W-1:0] stall_cnt, stall_inc, stall_d;
   logic            held;

   always_comb begin
      held      = prev_en && (count == prev_count);
      stall_inc = '0;
      if (held)
         stall_inc = (stall_cnt == LIMIT) ? LIMIT : stall_cnt + SC_W'(1);
      evt_stall = held && (stall_inc == LIMIT);
      stall_d   = stall_inc;
      // restart the hold count so a persisting stall re-arms from zero
      if ((state_d == STALL) && (state_q != STALL))
         stall_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_cnt <= '0;
      else       stall_cnt <= stall_d;
   end
`else
   assign evt_stall = (STALL_LIMIT < 0);
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
                  else if (evt_stall) state_d = STALL;
         STALL:   if (!enable) state_d = IDLE;
                  else if (count != prev_count) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   assign events   = {evt_err, evt_stall, evt_match, evt_wrap};
   assign clr_bits = clr ? clr_mask : 4'b0000;
   assign status_d = (status & ~clr_bits) | events;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         prev_count <= '0;
         prev_en    <= 1'b0;
         status     <= 4'b0000;
         wrap_cnt   <= '0;
         irq        <= 1'b0;
      end else begin
         state_q    <= state_d;
         prev_count <= count;
         prev_en    <= enable;
         status     <= status_d;
         if (evt_wrap && (wrap_cnt != '1))
            wrap_cnt <= wrap_cnt + WRAP_W'(1);
         irq        <= |(status & irq_en);
      end
   end

   assign state = state_q;

endmodule
